counter_checker: RTL

COUNTER_CHECKER -- requirements
Module: counter_checker

---
 rtl/counter_checker.sv | 115 +++++++++++
 1 files changed

// File: rtl/counter_checker.sv
// Sequence checker for a free-running counter: acquires, locks after SYNC_COUNT
// consecutive +1 samples, and counts sequence breaks seen while locked.
module counter_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SYNC_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             count_valid,
  input  logic             clear_errors,
  output logic             locked,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [7:0]       error_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    SYNC    = 2'd1,
    LOCKED  = 2'd2
  } state_e;

  localparam logic [3:0] RUN_LOCK = 4'(SYNC_COUNT);
  localparam logic [7:0] ERR_MAX  = '1;

  state_e           state_q, state_d;
  logic [3:0]       run_q, run_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [7:0]       error_count_q, error_count_d;
  logic             mismatch_q, mismatch_d;

  logic [WIDTH-1:0] next_val;
  logic [3:0]       run_inc;
  logic             match;
  logic             err_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ACQUIRE;
      run_q         <= '0;
      expected_q    <= '0;
      error_count_q <= '0;
      mismatch_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      run_q         <= run_d;
      expected_q    <= expected_d;
      error_count_q <= error_count_d;
      mismatch_q    <= mismatch_d;
    end
  end

  always_comb begin
    next_val      = count_in + WIDTH'(1);
    run_inc       = run_q + 4'd1;
    match         = (count_in == expected_q);
    err_inc       = 1'b0;
    state_d       = state_q;
    run_d         = run_q;
    expected_d    = expected_q;
    mismatch_d    = 1'b0;

    case (state_q)
      ACQUIRE: begin
        if (count_valid) begin
          expected_d = next_val;
          run_d      = 4'd1;
          state_d    = SYNC;
        end
      end
      SYNC: begin
        if (count_valid) begin
          expected_d = next_val;
          if (match) begin
            run_d = run_inc;
            if (run_inc == RUN_LOCK) state_d = LOCKED;
          end else begin
            run_d = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (count_valid) begin
          expected_d = next_val;
          if (!match) begin
            mismatch_d = 1'b1;
            err_inc    = 1'b1;
            run_d      = 4'd1;
            state_d    = SYNC;
          end
        end
      end
      default: state_d = ACQUIRE;
    endcase

    // Clear wins over the old value but a coincident mismatch still counts once.
    if (clear_errors)
      error_count_d = err_inc ? 8'd1 : 8'd0;
    else if (err_inc && error_count_q != ERR_MAX)
      error_count_d = error_count_q + 8'd1;
    else
      error_count_d = error_count_q;
  end

  always_comb begin
    locked      = (state_q == LOCKED);
    mismatch    = mismatch_q;
    expected    = expected_q;
    error_count = error_count_q;
    state       = state_q;
  end

endmodule
